load_store_unit: RTL and testbench

//   Sits between the core's execute stage and the word-only data memory.
//   - Turns RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into whole-word memory accesses.
//   - Loads: extracts the addressed byte/halfword and sign- or zero-extends it.
//   - Sub-word stores: read-modify-write, because the memory writes whole words only.
//   - Memory interface: reads return one cycle after mem_read is sampled; data_out is 0 when not reading.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-only data memory: byte/halfword loads are
// extracted and extended, and sub-word stores are done as read-modify-write.
module load_store_unit #(
    parameter bit RMW_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic        store_q, store_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    // Misaligned address or unsupported funct3 for the given direction.
    function automatic logic is_bad(input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case ({st, f3})
            4'b0_000, 4'b0_100: bad = 1'b0;
            4'b0_001, 4'b0_101: bad = off[0];
            4'b1_000:           bad = !RMW_EN;
            4'b1_001:           bad = off[0] || !RMW_EN;
            4'b0_010, 4'b1_010: bad = (off != 2'b00);
            default:            bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'h0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Only the addressed lane changes; everything else keeps the word just read.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] nd,
                                          input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        if (f3[0]) begin
            if (off[1]) res[31:16] = nd[15:0];
            else        res[15:0]  = nd[15:0];
        end else begin
            case (off)
                2'd0:    res[7:0]   = nd[7:0];
                2'd1:    res[15:8]  = nd[7:0];
                2'd2:    res[23:16] = nd[7:0];
                default: res[31:24] = nd[7:0];
            endcase
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        store_d     = store_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        load_data_d = load_data_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    store_d = req_store;
                    wdata_d = req_wdata;
                    err_d   = is_bad(req_store, req_funct3, req_addr[1:0]);
                    if (err_d) begin
                        state_d = FIN;
                    end else if (req_store && req_funct3 == 3'b010) begin
                        mem_wdata_d = req_wdata;
                        state_d     = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (store_q) begin
                    mem_wdata_d = merge(mem_rdata, wdata_q, f3_q, addr_q[1:0]);
                    state_d     = WR;
                end else begin
                    load_data_d = extract(mem_rdata, f3_q, addr_q[1:0]);
                    state_d     = FIN;
                end
            end
            WR:      state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            f3_q        <= '0;
            store_q     <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            store_q     <= store_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills them at once.
    assign req_ready = (state_q == IDLE);
    assign done      = (state_q == FIN);
    assign err       = (state_q == FIN) && err_q;
    assign mem_read  = (state_q == RD);
    assign mem_write = (state_q == WR);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_wdata_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model that answers
// one cycle after mem_read is sampled.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    load_store_unit #(.RMW_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .done(done), .err(err), .load_data(load_data),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem_read ? mem[mem_addr[7:2]] : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and follow it to its done pulse.
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic e, output logic [31:0] ld,
                          output logic acc);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        acc = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111;
        req_addr = 32'hDEAD_BEEF; req_wdata = ~wd;
        lat = 1;
        while (!done && lat < 20) begin
            acc = acc | mem_read | mem_write;
            @(posedge clk); #1;
            lat++;
        end
        acc = acc | mem_read | mem_write;
        e   = err;
        ld  = load_data;
        chk({tag, "_done"}, {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'h0, done}, 32'h0);
    endtask

    int          lat;
    logic        e;
    logic [31:0] ld;
    logic        acc;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_done",  {31'h0, done}, 32'h0);
        chk("rst_err",   {31'h0, err}, 32'h0);
        chk("rst_ld",    load_data, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_rdwr",  {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store then word load back
        run_op("sw10", 1'b1, 3'b010, 32'h10, 32'h1122_3344, lat, e, ld, acc);
        chk("sw10_lat", 32'(lat), 32'd2);
        chk("sw10_err", {31'h0, e}, 32'h0);
        run_op("lw10", 1'b0, 3'b010, 32'h10, 32'h0, lat, e, ld, acc);
        chk("lw10_lat", 32'(lat), 32'd3);
        chk("lw10_data", ld, 32'h1122_3344);
        chk("lw10_err", {31'h0, e}, 32'h0);

        // Sub-word loads with sign and zero extension
        run_op("sw20", 1'b1, 3'b010, 32'h20, 32'h80FF_7F01, lat, e, ld, acc);
        run_op("lb23", 1'b0, 3'b000, 32'h23, 32'h0, lat, e, ld, acc);
        chk("lb23_lat", 32'(lat), 32'd3);
        chk("lb23_data", ld, 32'hFFFF_FF80);
        run_op("lbu23", 1'b0, 3'b100, 32'h23, 32'h0, lat, e, ld, acc);
        chk("lbu23_data", ld, 32'h0000_0080);
        run_op("lh22", 1'b0, 3'b001, 32'h22, 32'h0, lat, e, ld, acc);
        chk("lh22_data", ld, 32'hFFFF_80FF);
        run_op("lhu20", 1'b0, 3'b101, 32'h20, 32'h0, lat, e, ld, acc);
        chk("lhu20_data", ld, 32'h0000_7F01);
        run_op("lb21", 1'b0, 3'b000, 32'h21, 32'h0, lat, e, ld, acc);
        chk("lb21_data", ld, 32'h0000_007F);

        // Read-modify-write sub-word stores
        run_op("sw30", 1'b1, 3'b010, 32'h30, 32'hAABB_CCDD, lat, e, ld, acc);
        run_op("sb31", 1'b1, 3'b000, 32'h31, 32'hFFFF_FF55, lat, e, ld, acc);
        chk("sb31_err", {31'h0, e}, 32'h0);
        run_op("lw30a", 1'b0, 3'b010, 32'h30, 32'h0, lat, e, ld, acc);
        chk("sb31_word", ld, 32'hAABB_55DD);
        run_op("sh32", 1'b1, 3'b001, 32'h32, 32'hABCD_1234, lat, e, ld, acc);
        chk("sh32_err", {31'h0, e}, 32'h0);
        run_op("lw30b", 1'b0, 3'b010, 32'h30, 32'h0, lat, e, ld, acc);
        chk("sh32_word", ld, 32'h1234_55DD);

        // Rejected requests: immediate done+err, no memory traffic, load_data kept
        run_op("lw41", 1'b0, 3'b010, 32'h41, 32'h0, lat, e, ld, acc);
        chk("lw41_lat", 32'(lat), 32'd1);
        chk("lw41_err", {31'h0, e}, 32'h1);
        chk("lw41_acc", {31'h0, acc}, 32'h0);
        chk("lw41_ld", ld, 32'h1234_55DD);
        run_op("sh43", 1'b1, 3'b001, 32'h43, 32'h0000_9999, lat, e, ld, acc);
        chk("sh43_lat", 32'(lat), 32'd1);
        chk("sh43_err", {31'h0, e}, 32'h1);
        chk("sh43_acc", {31'h0, acc}, 32'h0);
        chk("sh43_ld", ld, 32'h1234_55DD);
        run_op("ld011", 1'b0, 3'b011, 32'h40, 32'h0, lat, e, ld, acc);
        chk("ld011_err", {31'h0, e}, 32'h1);
        chk("ld011_acc", {31'h0, acc}, 32'h0);
        run_op("st100", 1'b1, 3'b100, 32'h40, 32'h0, lat, e, ld, acc);
        chk("st100_err", {31'h0, e}, 32'h1);
        chk("st100_acc", {31'h0, acc}, 32'h0);
        run_op("lw30c", 1'b0, 3'b010, 32'h30, 32'h0, lat, e, ld, acc);
        chk("lw30c_err", {31'h0, e}, 32'h0);

        // Reset while the RMW write is in flight
        run_op("sw50", 1'b1, 3'b010, 32'h50, 32'h0, lat, e, ld, acc);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h50; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_inwr", {30'h0, mem_read, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_wrdrop", {30'h0, mem_read, mem_write}, 32'h0);
        chk("abort_nodone", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        chk("abort_nodone2", {31'h0, done}, 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_nodone3", {31'h0, done}, 32'h0);
        run_op("lw50", 1'b0, 3'b010, 32'h50, 32'h0, lat, e, ld, acc);
        chk("lw50_data", ld, 32'h0);

        // Back-to-back loads with req_valid held high
        begin
            logic [2:0]  f3s [4];
            logic [31:0] as  [4];
            logic [31:0] exs [4];
            int issued, dn, last_acc;
            logic rdy;
            f3s[0] = 3'b010; as[0] = 32'h10; exs[0] = 32'h1122_3344;
            f3s[1] = 3'b100; as[1] = 32'h21; exs[1] = 32'h0000_007F;
            f3s[2] = 3'b001; as[2] = 32'h30; exs[2] = 32'h0000_55DD;
            f3s[3] = 3'b000; as[3] = 32'h33; exs[3] = 32'h0000_0012;
            issued = 0; dn = 0; last_acc = -1;
            req_valid = 1'b1; req_store = 1'b0; req_funct3 = f3s[0]; req_addr = as[0];
            for (int cyc = 0; cyc < 40 && dn < 4; cyc++) begin
                rdy = req_ready;
                @(posedge clk); #1;
                if (rdy && req_valid) begin
                    if (last_acc >= 0) chk("b2b_gap", 32'(cyc - last_acc), 32'd4);
                    last_acc = cyc;
                    issued++;
                    if (issued < 4) begin
                        req_funct3 = f3s[issued]; req_addr = as[issued];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
                if (done) begin
                    chk("b2b_data", load_data, exs[dn]);
                    dn++;
                end
            end
            req_valid = 1'b0;
            chk("b2b_issued", 32'(issued), 32'd4);
            chk("b2b_dones", 32'(dn), 32'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
